// File: rtl/riscv_uart_tx_if.sv
// Bus between the io bridge and the UART transmitter: byte write strobe in, FIFO/line status out.
// master = io bridge side, slave = transmitter side.
interface riscv_uart_tx_if #(
    parameter int FIFO_DEPTH = 16
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic             wr_en;
    logic [7:0]       wr_data;
    logic             full;
    logic             empty;
    logic             busy;
    logic [LVL_W-1:0] level;
    logic             overflow;
    logic             tx_done;
    logic             tx;

    modport master (
        output wr_en, wr_data,
        input  full, empty, busy, level, overflow, tx_done, tx
    );

    modport slave (
        input  wr_en, wr_data,
        output full, empty, busy, level, overflow, tx_done, tx
    );
endinterface

// File: rtl/riscv_uart_tx.sv
// Memory-mapped UART transmitter: byte FIFO feeding an 8N1, LSB-first serialiser with a registered tx pin.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module riscv_uart_tx #(
    parameter int CLKS_PER_BIT = 200,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    riscv_uart_tx_if.slave bus
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              done_q, done_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
`ifdef UART_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    logic [7:0] mem_q [FIFO_DEPTH];
    logic       full;
    logic       empty;
    logic       pop;
    logic       wr_accept;
    logic       bit_end;
    logic [7:0] head;

    assign full    = (count_q == LVL_FULL);
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign bit_end = (baud_q == BAUD_LAST);

    // Frame sequencer. tx_d is what the line shows for the current state, so the pin lags the
    // state register by one cycle; every bit still lasts exactly CLKS_PER_BIT cycles.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = 1'b1;
        done_d  = 1'b0;
        pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = head;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^head;
`endif
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            DATA: begin
                tx_d = shift_q[0];
                if (bit_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                tx_d = parity_q;
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = STOP;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
`endif
            STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    done_d = 1'b1;
                    baud_d = '0;
                    // Chain straight into the next start bit when another byte is waiting.
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = head;
`ifdef UART_TX_PARITY_EN
                        parity_d = ^head;
`endif
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = '0;
            end
        endcase
    end

    // FIFO bookkeeping. A write while full is dropped even if a pop frees a slot this cycle.
    always_comb begin
        wr_accept  = bus.wr_en && !full;
        overflow_d = overflow_q | (bus.wr_en & full);
        wr_ptr_d   = wr_accept ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({wr_accept, pop})
            2'b10:   count_d = count_q + LVL_W'(1);
            2'b01:   count_d = count_q - LVL_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= 3'd0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Payload storage carries no reset; it is only read after being written.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q] <= bus.wr_data;
        end
        shift_q <= shift_d;
`ifdef UART_TX_PARITY_EN
        parity_q <= parity_d;
`endif
    end

    assign bus.tx       = tx_q;
    assign bus.tx_done  = done_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.level    = count_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_riscv_uart_tx.sv
// Bench for riscv_uart_tx: a line monitor decodes every frame against a queue of expected bytes.
module tb_riscv_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = FRAME_BITS * CPB;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    riscv_uart_tx_if #(.FIFO_DEPTH(DEPTH)) bus();

    riscv_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]            exp_q[$];
    int                    start_cyc[$];
    int                    start_lvl[$];
    bit                    mon_active = 1'b0;
    int                    k = 0;
    int                    done_cnt = 0;
    int                    done_k = -1;
    bit                    done_ok = 1'b1;
    logic [7:0]            cur;
    logic [FRAME_BITS-1:0] pat;

    function automatic logic [FRAME_BITS-1:0] frame_pat(input logic [7:0] b);
        logic [FRAME_BITS-1:0] p;
        p      = '1;
        p[0]   = 1'b0;
        p[8:1] = b;
`ifdef UART_TX_PARITY_EN
        p[9]   = ^b;
`endif
        return p;
    endfunction

    // Line monitor: samples on the falling edge, checks each bit mid-cell and the tx_done position.
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_active = 1'b0;
        end else begin
            if (bus.tx_done === 1'b1) done_cnt++;
            if (!mon_active && bus.tx === 1'b0) begin
                mon_active = 1'b1;
                k = 0;
                done_ok = 1'b1;
                start_cyc.push_back(cyc);
                start_lvl.push_back(int'(bus.level));
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    pat = '1;
                    $display("FAIL frame_unexpected: start bit seen, required no frame");
                end else begin
                    cur = exp_q.pop_front();
                    pat = frame_pat(cur);
                end
            end
            if (mon_active) begin
                if (bus.tx_done !== (k == FRAME_CYC - 1)) done_ok = 1'b0;
                if (bus.tx_done === 1'b1) done_k = k;
                if (k % CPB == CPB / 2) begin
                    total++;
                    if (bus.tx !== pat[k / CPB]) begin
                        bad++;
                        $display("FAIL frame_bit byte=%h bit=%0d: got %b required %b", cur, k / CPB, bus.tx, pat[k / CPB]);
                    end
                end
                k++;
                if (k == FRAME_CYC) begin
                    mon_active = 1'b0;
                    total++;
                    if (!done_ok) begin
                        bad++;
                        $display("FAIL tx_done_pos byte=%h: got last pulse at cycle %0d required %0d", cur, done_k, FRAME_CYC - 1);
                    end
                end
            end
        end
    end

    task automatic wr(input logic [7:0] b);
        bus.wr_en   = 1'b1;
        bus.wr_data = b;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && !mon_active && bus.busy === 1'b0 && bus.empty === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s_timeout: got %0d frames pending after %0d cycles, required 0", name, exp_q.size(), budget);
        end
    endtask

    task automatic test_reset();
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total += 7;
        if (bus.tx !== 1'b1)       begin bad++; $display("FAIL rst_tx: got %b required 1", bus.tx); end
        if (bus.busy !== 1'b0)     begin bad++; $display("FAIL rst_busy: got %b required 0", bus.busy); end
        if (bus.empty !== 1'b1)    begin bad++; $display("FAIL rst_empty: got %b required 1", bus.empty); end
        if (bus.full !== 1'b0)     begin bad++; $display("FAIL rst_full: got %b required 0", bus.full); end
        if (bus.level !== 3'd0)    begin bad++; $display("FAIL rst_level: got %0d required 0", bus.level); end
        if (bus.overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow: got %b required 0", bus.overflow); end
        if (bus.tx_done !== 1'b0)  begin bad++; $display("FAIL rst_tx_done: got %b required 0", bus.tx_done); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (bus.tx !== 1'b1) begin bad++; $display("FAIL post_rst_tx: got %b required 1", bus.tx); end
    endtask

    task automatic test_single();
        int d0;
        d0 = done_cnt;
        exp_q.push_back(8'hA5);
        wr(8'hA5);
        total += 3;
        if (bus.level !== 3'd1) begin bad++; $display("FAIL single_level_w: got %0d required 1", bus.level); end
        if (bus.empty !== 1'b0) begin bad++; $display("FAIL single_empty_w: got %b required 0", bus.empty); end
        if (bus.tx !== 1'b1)    begin bad++; $display("FAIL single_tx_e0: got %b required 1", bus.tx); end
        @(negedge clk);
        total += 3;
        if (bus.tx !== 1'b1)    begin bad++; $display("FAIL single_tx_e1: got %b required 1", bus.tx); end
        if (bus.busy !== 1'b1)  begin bad++; $display("FAIL single_busy_e1: got %b required 1", bus.busy); end
        if (bus.level !== 3'd0) begin bad++; $display("FAIL single_level_pop: got %0d required 0", bus.level); end
        @(negedge clk);
        total++;
        if (bus.tx !== 1'b0)    begin bad++; $display("FAIL single_tx_e2: got %b required 0", bus.tx); end
        wait_idle(FRAME_CYC + 20, "single");
        total++;
        if (done_cnt - d0 !== 1) begin bad++; $display("FAIL single_done_count: got %0d required 1", done_cnt - d0); end
    endtask

    task automatic test_back_to_back();
        int n0;
        n0 = start_cyc.size();
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h03);
        wr(8'h01);
        total++;
        if (bus.level !== 3'd1) begin bad++; $display("FAIL b2b_level_1: got %0d required 1", bus.level); end
        wr(8'h02);
        total++;
        if (bus.level !== 3'd1) begin bad++; $display("FAIL b2b_level_2: got %0d required 1", bus.level); end
        wr(8'h03);
        total++;
        if (bus.level !== 3'd2) begin bad++; $display("FAIL b2b_level_3: got %0d required 2", bus.level); end
        wait_idle(3 * FRAME_CYC + 30, "b2b");
        total++;
        if (start_cyc.size() - n0 !== 3) begin
            bad++;
            $display("FAIL b2b_frames: got %0d required 3", start_cyc.size() - n0);
        end else begin
            for (int i = 1; i < 3; i++) begin
                total++;
                if (start_cyc[n0 + i] - start_cyc[n0 + i - 1] !== FRAME_CYC) begin
                    bad++;
                    $display("FAIL b2b_gap%0d: got %0d cycles required %0d", i, start_cyc[n0 + i] - start_cyc[n0 + i - 1], FRAME_CYC);
                end
            end
            for (int i = 0; i < 3; i++) begin
                total++;
                if (start_lvl[n0 + i] !== 2 - i) begin
                    bad++;
                    $display("FAIL b2b_start_level%0d: got %0d required %0d", i, start_lvl[n0 + i], 2 - i);
                end
            end
        end
        total++;
        if (bus.empty !== 1'b1) begin bad++; $display("FAIL b2b_empty: got %b required 1", bus.empty); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(8'h10 + 8'(i));
            wr(8'h10 + 8'(i));
        end
        total += 3;
        if (bus.level !== 3'd4)    begin bad++; $display("FAIL ovf_level_full: got %0d required 4", bus.level); end
        if (bus.full !== 1'b1)     begin bad++; $display("FAIL ovf_full: got %b required 1", bus.full); end
        if (bus.overflow !== 1'b0) begin bad++; $display("FAIL ovf_early: got %b required 0", bus.overflow); end
        wr(8'hEE);
        total += 2;
        if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b required 1", bus.overflow); end
        if (bus.level !== 3'd4)    begin bad++; $display("FAIL ovf_level_drop: got %0d required 4", bus.level); end
        wait_idle(5 * FRAME_CYC + 40, "ovf");
        total++;
        if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b required 1", bus.overflow); end
    endtask

    task automatic test_reset_mid();
        int lows;
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFF);
        wr(8'hFF);
        wr(8'hFF);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total += 5;
        if (bus.tx !== 1'b1)       begin bad++; $display("FAIL rmid_tx: got %b required 1", bus.tx); end
        if (bus.busy !== 1'b0)     begin bad++; $display("FAIL rmid_busy: got %b required 0", bus.busy); end
        if (bus.level !== 3'd0)    begin bad++; $display("FAIL rmid_level: got %0d required 0", bus.level); end
        if (bus.empty !== 1'b1)    begin bad++; $display("FAIL rmid_empty: got %b required 1", bus.empty); end
        if (bus.overflow !== 1'b0) begin bad++; $display("FAIL rmid_overflow: got %b required 0", bus.overflow); end
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.tx !== 1'b1) lows++;
        end
        total += 2;
        if (lows !== 0)         begin bad++; $display("FAIL rmid_line_idle: got %0d low cycles required 0", lows); end
        if (bus.busy !== 1'b0)  begin bad++; $display("FAIL rmid_busy_after: got %b required 0", bus.busy); end
    endtask

    task automatic test_simul_pop();
        int n0;
        n0 = start_cyc.size();
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hC3);
        exp_q.push_back(8'h5A);
        wr(8'h3C);
        wr(8'hC3);
        wr(8'h5A);
        total++;
        if (bus.level !== 3'd2) begin bad++; $display("FAIL simul_level_pre: got %0d required 2", bus.level); end
        repeat (FRAME_CYC - 2) @(negedge clk);
        total += 2;
        if (bus.level !== 3'd2)    begin bad++; $display("FAIL simul_level_stop: got %0d required 2", bus.level); end
        if (bus.tx_done !== 1'b0)  begin bad++; $display("FAIL simul_done_early: got %b required 0", bus.tx_done); end
        exp_q.push_back(8'h99);
        wr(8'h99);
        total += 3;
        if (bus.level !== 3'd2)    begin bad++; $display("FAIL simul_level_same: got %0d required 2", bus.level); end
        if (bus.tx_done !== 1'b1)  begin bad++; $display("FAIL simul_done: got %b required 1", bus.tx_done); end
        if (bus.tx !== 1'b1)       begin bad++; $display("FAIL simul_stop_tx: got %b required 1", bus.tx); end
        @(negedge clk);
        total++;
        if (bus.tx !== 1'b0)       begin bad++; $display("FAIL simul_next_start: got %b required 0", bus.tx); end
        wait_idle(4 * FRAME_CYC + 40, "simul");
        total++;
        if (start_cyc.size() - n0 !== 4) begin
            bad++;
            $display("FAIL simul_frames: got %0d required 4", start_cyc.size() - n0);
        end else begin
            total++;
            if (start_cyc[n0 + 1] - start_cyc[n0] !== FRAME_CYC) begin
                bad++;
                $display("FAIL simul_gap: got %0d cycles required %0d", start_cyc[n0 + 1] - start_cyc[n0], FRAME_CYC);
            end
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        done_k = -1;
        exp_q.push_back(8'h07);
        wr(8'h07);
        wait_idle(FRAME_CYC + 20, "parity");
        total++;
        if (done_k !== 43) begin bad++; $display("FAIL parity_done_cycle: got %0d required 43", done_k); end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        test_simul_pop();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
